// File: rtl/mult_div_unit.sv
// Iterative 32-bit MIPS multiply/divide unit (MULT, MULTU, DIV, DIVU) driving HI/LO.
// Optional single-cycle multiply path: define MDU_FAST_MULT_EN.
module mult_div_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic [31:0] hi_d,
   output logic [31:0] lo_d,
   output logic        hi_lo_we
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t      state_reg, state_next;
   logic [4:0]  count_reg;
   logic [63:0] acc_reg, acc_next;
   logic [31:0] mag_b_reg;
   logic [31:0] a_orig_reg;
   logic        is_div_reg;
   logic        neg_res_reg;
   logic        neg_rem_reg;
   logic        b_zero_reg;
   logic        we_reg;

   logic        accept;
   logic        signed_op;
   logic [31:0] mag_a_in, mag_b_in;
   logic        last_step;
   logic [32:0] mul_sum;
   logic [32:0] div_trial;
   logic [63:0] prod_neg;
   logic [31:0] fix_hi, fix_lo;

   assign accept    = (state_reg == S_IDLE) && start;
   assign signed_op = ~op[0];
   assign mag_a_in  = (signed_op && a[31]) ? (32'd0 - a) : a;
   assign mag_b_in  = (signed_op && b[31]) ? (32'd0 - b) : b;

`ifdef MDU_FAST_MULT_EN
   logic [63:0] fast_prod;
   assign fast_prod = acc_reg[31:0] * mag_b_reg;
   assign last_step = (count_reg == 5'd31) || !is_div_reg;
`else
   assign last_step = (count_reg == 5'd31);
`endif

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_reg <= S_IDLE;
      else
         state_reg <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         S_IDLE:  if (start) state_next = S_CALC;
         S_CALC:  if (last_step) state_next = S_FIX;
         S_FIX:   state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Outputs: busy spans the cycle in which the write strobe is presented
   always_comb begin
      busy     = (state_reg != S_IDLE) || we_reg;
      hi_lo_we = we_reg;
   end

   // One iteration step; accumulator starts as {0, |a|}
   assign mul_sum   = {1'b0, acc_reg[63:32]} + {1'b0, mag_b_reg};
   assign div_trial = acc_reg[63:31] - {1'b0, mag_b_reg};

   always_comb begin
      acc_next = acc_reg;
      if (is_div_reg) begin
         if (!div_trial[32])
            acc_next = {div_trial[31:0], acc_reg[30:0], 1'b1};
         else
            acc_next = {acc_reg[62:0], 1'b0};
      end else begin
         if (acc_reg[0])
            acc_next = {mul_sum, acc_reg[31:1]};
         else
            acc_next = {1'b0, acc_reg[63:1]};
      end
`ifdef MDU_FAST_MULT_EN
      if (!is_div_reg)
         acc_next = fast_prod;
`endif
   end

   // Sign correction; divide by zero returns the original dividend in HI
   assign prod_neg = 64'd0 - acc_reg;

   always_comb begin
      fix_hi = acc_reg[63:32];
      fix_lo = acc_reg[31:0];
      if (!is_div_reg) begin
         if (neg_res_reg) begin
            fix_hi = prod_neg[63:32];
            fix_lo = prod_neg[31:0];
         end
      end else if (b_zero_reg) begin
         fix_hi = a_orig_reg;
         fix_lo = 32'hFFFF_FFFF;
      end else begin
         if (neg_res_reg) fix_lo = 32'd0 - acc_reg[31:0];
         if (neg_rem_reg) fix_hi = 32'd0 - acc_reg[63:32];
      end
   end

   // Datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_reg   <= 5'd0;
         acc_reg     <= 64'd0;
         mag_b_reg   <= 32'd0;
         a_orig_reg  <= 32'd0;
         is_div_reg  <= 1'b0;
         neg_res_reg <= 1'b0;
         neg_rem_reg <= 1'b0;
         b_zero_reg  <= 1'b0;
         we_reg      <= 1'b0;
         hi_d        <= 32'd0;
         lo_d        <= 32'd0;
      end else begin
         we_reg <= (state_reg == S_FIX);
         if (accept) begin
            count_reg   <= 5'd0;
            acc_reg     <= {32'd0, mag_a_in};
            mag_b_reg   <= mag_b_in;
            a_orig_reg  <= a;
            is_div_reg  <= op[1];
            neg_res_reg <= signed_op && (a[31] ^ b[31]);
            neg_rem_reg <= signed_op && a[31];
            b_zero_reg  <= (b == 32'd0);
         end else if (state_reg == S_CALC) begin
            count_reg <= count_reg + 5'd1;
            acc_reg   <= acc_next;
         end else if (state_reg == S_FIX) begin
            hi_d <= fix_hi;
            lo_d <= fix_lo;
         end
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed cases plus randomized ops vs a 64-bit arithmetic model.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic        busy;
   logic [31:0] hi_d, lo_d;
   logic        hi_lo_we;

   mult_div_unit dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .hi_d(hi_d), .lo_d(lo_d), .hi_lo_we(hi_lo_we)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          we_cyc;
   } exp_t;

   exp_t exp_q[$];
   int checks = 0;
   int failures = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic checki(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Reference: plain 64-bit arithmetic
   function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] h, output logic [31:0] l);
      longint          sx, sy, p, q, r;
      longint unsigned up;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      h = 32'd0;
      l = 32'd0;
      case (o)
         2'b00: begin p = sx * sy; h = p[63:32]; l = p[31:0]; end
         2'b01: begin up = {32'd0, x} * {32'd0, y}; h = up[63:32]; l = up[31:0]; end
         2'b10: begin
            if (y == 32'd0) begin h = x; l = 32'hFFFF_FFFF; end
            else begin q = sx / sy; r = sx % sy; h = r[31:0]; l = q[31:0]; end
         end
         default: begin
            if (y == 32'd0) begin h = x; l = 32'hFFFF_FFFF; end
            else begin h = x % y; l = x / y; end
         end
      endcase
   endfunction

   function automatic int we_latency(input logic [1:0] o);
`ifdef MDU_FAST_MULT_EN
      return o[1] ? 33 : 2;
`else
      return 33;
`endif
   endfunction

   task automatic push_exp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input int acc);
      exp_t e;
      model(o, x, y, e.hi, e.lo);
      e.we_cyc = acc + we_latency(o);
      exp_q.push_back(e);
      $display("issue op=%0d a=%h b=%h accepted_at=%0d exp_hi=%h exp_lo=%h", o, x, y, acc, e.hi, e.lo);
   endtask

   // Must be called while the unit is idle, ends at the negedge after the accepting edge
   task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, output int acc);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk);
      #1;
      acc = cyc;
      push_exp(o, x, y, acc);
      @(negedge clk);
      check32("busy_after_accept", {31'd0, busy}, 32'd1);
      start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
   endtask

   task automatic finish_op(input logic [1:0] o, input int acc);
      int n;
      for (n = 0; n < 100; n++) begin
         @(negedge clk);
         if (!busy) break;
      end
      checki("busy_fall_cycle", cyc, acc + we_latency(o) + 1);
   endtask

   task automatic wait_until_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // Monitor: pops the scoreboard on every write strobe
   always @(negedge clk) begin
      if (hi_lo_we) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_we actual=pulse required=none cyc=%0d", cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            $display("result cyc=%0d hi=%h lo=%h", cyc, hi_d, lo_d);
            check32("hi", hi_d, e.hi);
            check32("lo", lo_d, e.lo);
            checki("we_cycle", cyc, e.we_cyc);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [1:0]  o;
      logic [31:0] x;
      logic [31:0] y;
   } dir_t;

   dir_t dir_tab[7] = '{
      '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
      '{2'b00, 32'hFFFF_FFFD, 32'd5},
      '{2'b10, 32'hFFFF_FFF9, 32'd2},
      '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF},
      '{2'b11, 32'd100,       32'd0},
      '{2'b10, 32'hFFFF_FF9C, 32'd0},
      '{2'b00, 32'h8000_0000, 32'h8000_0000}
   };

   initial begin
      int acc, acc1;
      logic [1:0]  ro;
      logic [31:0] rx, ry;

      reset = 1'b1; start = 1'b0; op = 2'd0; a = 32'd0; b = 32'd0;
      repeat (3) @(negedge clk);
      check32("reset_busy", {31'd0, busy}, 32'd0);
      check32("reset_we", {31'd0, hi_lo_we}, 32'd0);
      check32("reset_hi", hi_d, 32'd0);
      check32("reset_lo", lo_d, 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;

      foreach (dir_tab[i]) begin
         issue(dir_tab[i].o, dir_tab[i].x, dir_tab[i].y, acc);
         finish_op(dir_tab[i].o, acc);
      end

      // Start during busy is ignored
      issue(2'b11, 32'd100, 32'd7, acc);
      wait_until_cyc(acc + 9);
      start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      finish_op(2'b11, acc);

      // Start held across E33 (ignored) and E34 (accepted)
      issue(2'b11, pick(), pick(), acc);
      wait_until_cyc(acc + 32);
      start = 1'b1; op = 2'b00; a = 32'h1234_5678; b = 32'hFEDC_BA98;
      @(posedge clk);
      #1;
      check32("busy_at_E33", {31'd0, busy}, 32'd1);
      @(posedge clk);
      #1;
      acc1 = cyc;
      checki("accept_at_E34", acc1, acc + 34);
      push_exp(2'b00, 32'h1234_5678, 32'hFEDC_BA98, acc1);
      @(negedge clk);
      start = 1'b0;
      finish_op(2'b00, acc1);

      // Reset mid-operation aborts without a strobe
      issue(2'b11, 32'd1000, 32'd3, acc);
      wait_until_cyc(acc + 4);
      @(posedge clk);
      #1 reset = 1'b1;
      #1;
      check32("abort_busy", {31'd0, busy}, 32'd0);
      check32("abort_we", {31'd0, hi_lo_we}, 32'd0);
      check32("abort_hi", hi_d, 32'd0);
      check32("abort_lo", lo_d, 32'd0);
      void'(exp_q.pop_back());
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      issue(2'b01, 32'd2, 32'd3, acc);
      finish_op(2'b01, acc);

      for (int k = 0; k < 40; k++) begin
         ro = 2'($urandom_range(0, 3));
         rx = pick();
         ry = pick();
         issue(ro, rx, ry, acc);
         finish_op(ro, acc);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (5) @(negedge clk);
      checki("scoreboard_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
